// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch stage.
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Canonical RISC-V NOP (addi x0, x0, 0) used for pipeline bubbles.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // PC loaded on reset unless the instantiating level overrides it.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding buffer for a fetched {instr, pc} pair that
// arrived while decode was stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         pop,
  input  logic         clear,
  input  logic [31:0]  load_instr,
  input  logic [N-1:0] load_pc,
  output logic         valid,
  output logic [31:0]  instr,
  output logic [N-1:0] pc
);

  // Buffer update: clear wins over load, load wins over pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding instruction-memory handshake,
// one-entry skid buffer and IF/ID register feeding decode.
// Optional debug halt/single-step is enabled with `define FETCH_DEBUG_HALT_EN;
// without it halt_DB/step_DB are ignored and halted_DB is tied low.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_D,
  input  logic         redirect_E,
  input  logic [N-1:0] target_E,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_valid,
  input  logic [31:0]  imem_data,
  output logic [31:0]  instr_D,
  output logic [N-1:0] PC_D,
  output logic [N-1:0] PC_4,
  output logic         valid_D,
  input  logic         halt_DB,
  input  logic         step_DB,
  output logic         halted_DB
);

  fetch_state_t state, state_next;
  logic [N-1:0] pc, pc_next;
  logic         kill, kill_next;

  logic         fetch_req;
  logic         fetch_allow;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] target_aligned;

  logic         skid_load, skid_pop, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [N-1:0] skid_pc;

  logic         ifid_load;
  logic [31:0]  ifid_src_instr;
  logic [N-1:0] ifid_src_pc;
  logic [N-1:0] ifid_src_pc4;

  assign pc_plus4       = pc + N'(4);
  assign target_aligned = target_E & ~N'(3);
  assign ifid_src_pc4   = ifid_src_pc + N'(4);

  assign imem_req  = fetch_req;
  assign imem_addr = pc;

`ifdef FETCH_DEBUG_HALT_EN
  assign fetch_allow = ~halt_DB | step_DB;
  assign halted_DB   = reset & halt_DB & ((state == FETCH) | (state == IDLE));
`else
  logic unused_dbg;
  assign unused_dbg  = halt_DB ^ step_DB;
  assign fetch_allow = 1'b1;
  assign halted_DB   = 1'b0;
`endif

  fetch_skid #(
    .N(N)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .pop       (skid_pop),
    .clear     (skid_clear),
    .load_instr(imem_data),
    .load_pc   (pc),
    .valid     (skid_valid),
    .instr     (skid_instr),
    .pc        (skid_pc)
  );

  // Next-state, PC and handshake decisions; a redirect overrides stall and response.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    kill_next      = kill;
    fetch_req      = 1'b0;
    skid_load      = 1'b0;
    skid_pop       = 1'b0;
    skid_clear     = 1'b0;
    ifid_load      = 1'b0;
    ifid_src_instr = imem_data;
    ifid_src_pc    = pc;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        fetch_req = ~redirect_E & fetch_allow;
        if (fetch_req) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (redirect_E) begin
          if (imem_valid) begin
            kill_next  = 1'b0;
            state_next = FETCH;
          end else begin
            kill_next  = 1'b1;
          end
        end else if (imem_valid) begin
          if (kill) begin
            kill_next  = 1'b0;
            state_next = FETCH;
          end else if (!stall_D) begin
            ifid_load  = 1'b1;
            pc_next    = pc_plus4;
            state_next = FETCH;
          end else begin
            skid_load  = 1'b1;
            pc_next    = pc_plus4;
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_E) begin
          skid_clear = 1'b1;
          state_next = FETCH;
        end else if (!stall_D) begin
          skid_pop       = 1'b1;
          ifid_load      = skid_valid;
          ifid_src_instr = skid_instr;
          ifid_src_pc    = skid_pc;
          state_next     = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (redirect_E) begin
      pc_next = target_aligned;
    end
  end

  // Controller state, PC and kill flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      kill  <= kill_next;
    end
  end

  // IF/ID register: flushed on redirect, held on stall, otherwise loads data or a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_D <= 1'b0;
      instr_D <= NOP_INSTR;
      PC_D    <= '0;
      PC_4    <= '0;
    end else if (redirect_E) begin
      valid_D <= 1'b0;
      instr_D <= NOP_INSTR;
    end else if (!stall_D) begin
      if (ifid_load) begin
        valid_D <= 1'b1;
        instr_D <= ifid_src_instr;
        PC_D    <= ifid_src_pc;
        PC_4    <= ifid_src_pc4;
      end else begin
        valid_D <= 1'b0;
        instr_D <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage.
// Expected decode deliveries are derived from program order: each accepted
// fetch request pushes {pc, mem(pc)}; a redirect discards everything pending
// and restarts the expected PC at the aligned target.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int          N        = 64;
  localparam logic [N-1:0] START_PC = 64'h1000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall_D = 1'b0;
  logic         redirect_E = 1'b0;
  logic [N-1:0] target_E = '0;
  logic         imem_valid = 1'b0;
  logic [31:0]  imem_data = '0;
  logic         halt_DB = 1'b0;
  logic         step_DB = 1'b0;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [31:0]  instr_D;
  logic [N-1:0] PC_D;
  logic [N-1:0] PC_4;
  logic         valid_D;
  logic         halted_DB;

  typedef struct {
    logic [N-1:0] pc;
    logic [31:0]  instr;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] model_pc = START_PC;
  bit           outstanding = 0;
  bit           mon_en = 0;
  int           checks = 0;
  int           failures = 0;
  int           lat_min = 1;
  int           lat_max = 1;
  int           deliver_count = 0;

  fetch_stage #(
    .N       (N),
    .RESET_PC(START_PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall_D   (stall_D),
    .redirect_E(redirect_E),
    .target_E  (target_E),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_data (imem_data),
    .instr_D   (instr_D),
    .PC_D      (PC_D),
    .PC_4      (PC_4),
    .valid_D   (valid_D),
    .halt_DB   (halt_DB),
    .step_DB   (step_DB),
    .halted_DB (halted_DB)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0003;
  endfunction

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [N-1:0] tgt,
                               input logic halt, input logic step);
    @(posedge clk);
    #1;
    stall_D    = stall;
    redirect_E = redir;
    target_E   = tgt;
    halt_DB    = halt;
    step_DB    = step;
  endtask

  // Instruction memory: answers each request after lat_min..lat_max cycles.
  initial begin : responder
    int           cnt;
    logic [N-1:0] addr;
    bit           pend;
    pend = 0;
    cnt  = 0;
    addr = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem_word(addr);
          pend       = 0;
        end
      end
      @(negedge clk);
      if (reset && imem_req) begin
        pend = 1;
        addr = imem_addr;
        cnt  = int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  // Monitor: consumes decode deliveries against the scoreboard and tracks requests.
  initial begin : monitor
    exp_t e;
    exp_t tmp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!valid_D) checkOutput("bubble_nop", N'(instr_D), N'(NOP_INSTR));
`ifndef FETCH_DEBUG_HALT_EN
        checkOutput("halted_tied_low", N'(halted_DB), '0);
`endif
        if (valid_D && !stall_D && !redirect_E) begin
          deliver_count++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_instr: got pc %h expected none", PC_D);
          end else begin
            e = sb.pop_front();
            checkOutput("PC_D", PC_D, e.pc);
            checkOutput("PC_4", PC_4, e.pc + N'(4));
            checkOutput("instr_D", N'(instr_D), N'(e.instr));
          end
        end
        if (redirect_E) begin
          sb.delete();
          model_pc = target_E & ~N'(3);
        end
        if (imem_valid) outstanding = 0;
        if (imem_req) begin
          checkOutput("single_outstanding", N'(outstanding), '0);
          checkOutput("imem_addr", imem_addr, model_pc);
          tmp.pc    = model_pc;
          tmp.instr = mem_word(model_pc);
          sb.push_back(tmp);
          model_pc  = model_pc + N'(4);
          outstanding = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    bit           seen;
    int           n_req;
    int           n_del;
    logic [N-1:0] first_addr;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid_D", N'(valid_D), '0);
    checkOutput("rst_instr_D", N'(instr_D), N'(NOP_INSTR));
    checkOutput("rst_PC_D", PC_D, '0);
    checkOutput("rst_PC_4", PC_4, '0);
    checkOutput("rst_imem_req", N'(imem_req), '0);
    checkOutput("rst_halted", N'(halted_DB), '0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1;
    @(negedge clk);
    checkOutput("idle_no_req", N'(imem_req), '0);

    // First fetch with one-cycle memory
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      applyStimulus(0, 0, '0, 0, 0);
      @(negedge clk);
      if (imem_req) seen = 1;
    end
    checkOutput("first_req_seen", N'(seen), N'(1));
    checkOutput("first_req_addr", imem_addr, START_PC);
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("lat_valid_D", N'(valid_D), N'(1));
    checkOutput("lat_PC_D", PC_D, START_PC);
    checkOutput("lat_PC_4", PC_4, START_PC + N'(4));
    checkOutput("lat_next_req", N'(imem_req), N'(1));
    checkOutput("lat_next_addr", imem_addr, START_PC + N'(4));

    // Response arrives under a three-cycle stall
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, '0, 0, 0);
      @(negedge clk);
      checkOutput("stall_no_req", N'(imem_req), '0);
      checkOutput("stall_ifid_hold", N'(valid_D), '0);
    end
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    lat_min = 4;
    lat_max = 4;
    applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("release_valid", N'(valid_D), N'(1));
    checkOutput("release_PC_D", PC_D, START_PC + N'(4));
    checkOutput("release_req_addr", imem_addr, START_PC + N'(8));

    // Redirect to 0x2002 while waiting on a slow response
    applyStimulus(0, 1, 64'h2002, 0, 0);
    lat_min = 2;
    lat_max = 2;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1;
      else checkOutput("redirect_bubble", N'(valid_D), '0);
      if (!seen) applyStimulus(0, 0, '0, 0, 0);
    end
    checkOutput("redirect_req_seen", N'(seen), N'(1));
    checkOutput("redirect_req_addr", imem_addr, 64'h2000);

    // Redirect coinciding with a response and a stall
    applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(1, 1, 64'h3000, 0, 0);
    applyStimulus(1, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("coincide_flush", N'(valid_D), '0);
    checkOutput("coincide_req", N'(imem_req), N'(1));
    checkOutput("coincide_addr", imem_addr, 64'h3000);

    // PC wrap-around at the top of the address space
    lat_min = 1;
    lat_max = 1;
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    n_req = 0;
    first_addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin
        n_req++;
        if (n_req == 1) first_addr = imem_addr;
        if (n_req == 2) checkOutput("wrap_addr", imem_addr, '0);
      end
      applyStimulus(0, 0, '0, 0, 0);
    end
    checkOutput("wrap_first_addr", first_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_req_count_ok", N'(n_req >= 2), N'(1));

`ifdef FETCH_DEBUG_HALT_EN
    // Debug halt and single step
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(0, 0, '0, 1, 0);
      @(negedge clk);
      if (halted_DB) seen = 1;
    end
    checkOutput("halt_reached", N'(seen), N'(1));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, '0, 1, 0);
      @(negedge clk);
      checkOutput("halt_no_req", N'(imem_req), '0);
      checkOutput("halt_flag", N'(halted_DB), N'(1));
    end
    applyStimulus(0, 0, '0, 1, 1);
    @(negedge clk);
    checkOutput("step_req", N'(imem_req), N'(1));
    n_req = 0;
    n_del = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, '0, 1, 0);
      @(negedge clk);
      if (imem_req) n_req++;
      if (valid_D) n_del++;
    end
    checkOutput("step_extra_reqs", N'(n_req), '0);
    checkOutput("step_one_instr", N'(n_del), N'(1));
    checkOutput("step_rehalted", N'(halted_DB), N'(1));
`endif

    // Randomized traffic: stalls, redirects, variable latency, debug inputs
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] tgt;
      tgt = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) tgt = {32'hFFFF_FFFF, tgt[31:0]};
      applyStimulus(($urandom_range(9, 0) < 3), ($urandom_range(24, 0) == 0), tgt,
                    ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0));
    end
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, 0, 0);
    @(negedge clk);
    checkOutput("throughput_ok", N'(deliver_count > 200), N'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of decode.
- Owns the PC register and a single-outstanding-request handshake to instruction memory, with variable response latency.
- Contains a one-entry skid buffer and the IF/ID pipeline register that delivers instr_D, PC_D and PC_4 to decode.
- Handles decode stalls and branch/jump redirects from execute, including killing in-flight fetches.

Parameters:
- N, 64, PC/data width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stall_D  in  1  decode cannot accept; IF/ID holds.
- redirect_E  in  1  taken branch/jump in execute.
- target_E  in  N  redirect target; bits [1:0] forced to 0.
- imem_req  out  1  fetch request, one-cycle pulse.
- imem_addr  out  N  fetch address (current PC).
- imem_valid  in  1  response strobe.
- imem_data  in  32  response instruction.
- instr_D  out  32  IF/ID instruction; NOP 32'h00000013 when invalid.
- PC_D  out  N  IF/ID PC.
- PC_4  out  N  IF/ID PC+4.
- valid_D  out  1  IF/ID holds a real instruction.
- halt_DB  in  1  debug halt (optional feature).
- step_DB  in  1  debug single-step pulse (optional feature).
- halted_DB  out  1  fetch quiescent under halt.

Behaviour:
- Reset (reset==0 at clk edge) sets:
  - pc=RESET_PC, state=IDLE, kill=0, skid empty.
  - valid_D=0, instr_D=NOP, PC_D=0, PC_4=0.
  - imem_req=0, halted_DB=0.
- Reset mid-WAIT: the late response is ignored, because the state is IDLE.
- States:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: imem_req = ~redirect_E; imem_addr=pc. If the request is issued, go to WAIT. On redirect, set pc=target and stay in FETCH.
  - WAIT: wait for imem_valid.
    - kill set: drop the data, clear kill, go to FETCH.
    - kill clear and stall_D=0: load IF/ID, set pc=pc+4, go to FETCH.
    - kill clear and stall_D=1: store in skid, set pc=pc+4, go to HOLD.
  - HOLD: when stall_D=0, move skid into IF/ID and go to FETCH.
- Latency: best case is request in cycle t, response in t+1, IF/ID valid at t+2, next request at t+2. Throughput is therefore one instruction per 2 cycles minimum.
- IF/ID is updated only when stall_D=0 or on redirect. If stall_D=0 and no data is available, load a bubble (valid_D=0, instr_D=NOP).
- Redirect has priority over stall and response. Effects in the same cycle:
  - pc <= target_E & ~3.
  - IF/ID flushed to a bubble.
  - WAIT without imem_valid: set kill.
  - WAIT with imem_valid: drop the data, go to FETCH.
  - HOLD: discard the skid, go to FETCH.
- PC arithmetic is modulo 2^N; wrap-around from all-ones-minus-3 gives 0.
- At most one request is outstanding. imem_req is never asserted in WAIT or HOLD.

Optional Feature:
- Macro: FETCH_DEBUG_HALT_EN.
- With the macro:
  - While halt_DB=1, FETCH issues no request unless step_DB=1 that cycle, which permits exactly one request.
  - Outstanding and held instructions complete normally.
  - halted_DB=1 when halt_DB=1 and state is FETCH or IDLE.
  - Redirects are still accepted while halted.
- Without the macro: halt_DB and step_DB are ignored and halted_DB is tied to 0. The port list is unchanged.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, FETCH, WAIT, HOLD}.
  - NOP_INSTR constant (32'h00000013).
  - Default RESET_PC.
- Sub-module fetch_skid: one-entry buffer {instr, pc} with load/pop/clear and a valid flag.

Test Plan:
- Reset with RESET_PC=64'h1000, memory returns with 1-cycle latency -> requests at 0x1000, 0x1004, 0x1008. IF/ID shows PC_D=0x1000, PC_4=0x1004, valid_D=1 two cycles after the first request.
- Response arrives while stall_D=1 for 3 cycles -> state HOLD, no imem_req, IF/ID unchanged. On release, the held instruction appears and the next request goes to pc+4.
- Redirect_E with target 0x2002 during WAIT, response 4 cycles later -> the old instruction is dropped, valid_D=0 bubble, next request to 0x2000.
- Redirect in the same cycle as imem_valid and stall_D=1 -> no skid load, IF/ID flushed, FETCH next at the target.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0.
- FETCH_DEBUG_HALT_EN with halt_DB=1 -> no requests and halted_DB=1. A single step_DB pulse -> exactly one request and one valid instruction, then halted again.
